// File: rtl/voxel_pkg.sv
// Shared definitions for the voxel projector: view-mode encodings and FSM states.
package voxel_pkg;

    localparam logic [1:0] MODE_TOP   = 2'd0;
    localparam logic [1:0] MODE_FRONT = 2'd1;
    localparam logic [1:0] MODE_SIDE  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_TST,
        S_WR,
        S_DONE
    } state_e;

endpackage

// File: rtl/voxel_projector_if.sv
// Framebuffer write port: valid/ready handshake shared with other RAM writers.
interface voxel_projector_if #(
    parameter int FB_ADDR_W = 12
);
    logic                 fb_we;
    logic                 fb_ready;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_d;

    modport master (output fb_we, output fb_addr, output fb_d, input fb_ready);
    modport slave  (input fb_we, input fb_addr, input fb_d, output fb_ready);
endinterface

// File: rtl/voxel_store.sv
// N x N x N 1-bit voxel RAM, synchronous read, addressed {x,y,z}; contents survive reset.
module voxel_store #(
    parameter int VX_BITS     = 3,
    parameter int INIT_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic                 inhibit_i,
    input  logic [3*VX_BITS-1:0] addr_i,
    input  logic                 d_i,
    output logic                 q_o
);
    localparam int unsigned DEPTH = 1 << (3 * VX_BITS);

    // Power-up image: parity of x+y+z is the XOR of the three coordinate LSBs.
    function automatic logic [DEPTH-1:0] init_image();
        logic [DEPTH-1:0]     img;
        logic [3*VX_BITS-1:0] av;
        img = '0;
        if (INIT_PARITY != 0) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                av     = (3*VX_BITS)'(a);
                img[a] = av[2*VX_BITS] ^ av[VX_BITS] ^ av[0];
            end
        end
        return img;
    endfunction

    logic [DEPTH-1:0] mem_q = init_image();
    logic             q_q;

    always_ff @(posedge clk) begin
        if (we_i && !inhibit_i) begin
            mem_q[addr_i] <= d_i;
        end
        q_q <= mem_q[addr_i];
    end

    assign q_o = q_q;

endmodule

// File: rtl/voxel_projector.sv
// Projects the voxel store onto the framebuffer: nearest occupied voxel per column, depth-shaded.
module voxel_projector
    import voxel_pkg::*;
#(
    parameter int         VX_BITS     = 3,
    parameter int         FB_ADDR_W   = 12,
    parameter int         FB_BASE     = 0,
    parameter int         FB_STRIDE   = 32,
    parameter logic [7:0] BG_COLOR    = 8'h00,
    parameter int         INIT_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    input  logic                 vox_we,
    input  logic [3*VX_BITS-1:0] vox_addr,
    input  logic                 vox_d,
    output logic                 vox_err,
    voxel_projector_if.master    fb
);
    localparam logic [VX_BITS-1:0] LAST = '1;

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [VX_BITS-1:0]   u_q, u_d, v_q, v_d, d_q, d_d;
    logic [7:0]           pix_q, pix_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic                 err_q;

    logic [3*VX_BITS-1:0] rd_addr, store_addr;
    logic                 vox_q;
    logic [7:0]           shade;

    function automatic logic [FB_ADDR_W-1:0] pix_addr(logic [VX_BITS-1:0] u, logic [VX_BITS-1:0] v);
        return FB_ADDR_W'(FB_BASE + int'(v) * FB_STRIDE + int'(u));
    endfunction

    // Permute (u,v,depth) onto the store's {x,y,z}; mode 3 falls through to the top view.
    always_comb begin
        case (mode_q)
            MODE_FRONT: rd_addr = {u_q, d_q, v_q};
            MODE_SIDE:  rd_addr = {d_q, u_q, v_q};
            default:    rd_addr = {u_q, v_q, d_q};
        endcase
    end

    assign store_addr = busy ? rd_addr : vox_addr;
    assign shade      = 8'(d_q) << (8 - VX_BITS);

    voxel_store #(
        .VX_BITS    (VX_BITS),
        .INIT_PARITY(INIT_PARITY)
    ) u_store (
        .clk      (clk),
        .we_i     (vox_we),
        .inhibit_i(busy),
        .addr_i   (store_addr),
        .d_i      (vox_d),
        .q_o      (vox_q)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        u_d     = u_q;
        v_d     = v_q;
        d_d     = d_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD;
                    mode_d  = mode;
                    u_d     = '0;
                    v_d     = '0;
                    d_d     = '0;
                end
            end
            S_RD: state_d = S_TST;
            S_TST: begin
                if (vox_q || d_q == LAST) begin
                    pix_d   = vox_q ? 8'hFF - shade : BG_COLOR;
                    addr_d  = pix_addr(u_q, v_q);
                    state_d = S_WR;
                end else begin
                    d_d     = d_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (fb.fb_ready) begin
                    d_d = '0;
                    if (u_q == LAST && v_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                        u_d     = u_q + 1'b1;
                        if (u_q == LAST) begin
                            v_d = v_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            u_q     <= '0;
            v_q     <= '0;
            d_q     <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            u_q     <= u_d;
            v_q     <= v_d;
            d_q     <= d_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            err_q   <= vox_we && busy;
        end
    end

    assign busy       = (state_q == S_RD) || (state_q == S_TST) || (state_q == S_WR);
    assign done       = (state_q == S_DONE);
    assign vox_err    = err_q;
    assign fb.fb_we   = (state_q == S_WR);
    assign fb.fb_addr = addr_q;
    assign fb.fb_d    = pix_q;

endmodule

// File: tb/tb_voxel_projector.sv
// Directed + randomized bench for voxel_projector against a column-scan reference model.
module tb_voxel_projector;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset, start, vox_we, vox_d;
    logic [1:0] mode;
    logic [8:0] vox_addr;
    logic       busy, done, vox_err;

    voxel_projector_if #(.FB_ADDR_W(12)) fb ();

    voxel_projector #(
        .VX_BITS    (3),
        .FB_ADDR_W  (12),
        .FB_BASE    (0),
        .FB_STRIDE  (32),
        .BG_COLOR   (8'h00),
        .INIT_PARITY(1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .vox_we  (vox_we),
        .vox_addr(vox_addr),
        .vox_d   (vox_d),
        .vox_err (vox_err),
        .fb      (fb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    bit vox [N][N][N];
    int exp_addr [64];
    int exp_data [64];
    int exp_cost;
    int got_addr [64];
    int got_data [64];
    int saved_data [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan each column front to back, first occupied voxel wins.
    task automatic build_expected(input int m);
        int x, y, z, pix, cost;
        exp_cost = 0;
        for (int v = 0; v < N; v++) begin
            for (int u = 0; u < N; u++) begin
                pix  = 0;
                cost = 2 * N + 1;
                for (int d = 0; d < N; d++) begin
                    if (m == 1)      begin x = u; y = d; z = v; end
                    else if (m == 2) begin x = d; y = u; z = v; end
                    else             begin x = u; y = v; z = d; end
                    if (vox[x][y][z]) begin
                        pix  = 255 - d * (256 / N);
                        cost = 2 * (d + 1) + 1;
                        break;
                    end
                end
                exp_addr[v*N+u] = (v * 32 + u) % 4096;
                exp_data[v*N+u] = pix;
                exp_cost += cost;
            end
        end
    endtask

    task automatic vox_write(input int x, input int y, input int z, input bit d);
        @(negedge clk);
        vox_we   = 1'b1;
        vox_addr = {3'(x), 3'(y), 3'(z)};
        vox_d    = d;
        vox[x][y][z] = d;
        @(negedge clk);
        vox_we = 1'b0;
    endtask

    task automatic render(input logic [1:0] m, input bit rnd, input int hold,
                          input int abort_after, input bit disturb);
        int wr_cnt = 0, done_cnt = 0, busy_cyc = 0, cyc = 0, seen = 0;
        logic [11:0] ha;
        logic [7:0]  hd;
        bit rdy;
        build_expected(int'(m));
        for (int i = 0; i < 64; i++) begin got_addr[i] = -1; got_data[i] = -1; end
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        check("busy_after_start", busy, 1);
        while (cyc < 4000) begin
            if (done) begin
                done_cnt++;
                check("busy_in_done", busy, 0);
                break;
            end
            if (busy) busy_cyc++;
            if (disturb) begin
                if (cyc == 5) begin
                    vox_we   = 1'b1;
                    vox_addr = '0;
                    vox_d    = ~vox[0][0][0];
                    start    = 1'b1;
                    mode     = m ^ 2'b01;
                end
                if (cyc == 6) begin
                    vox_we = 1'b0;
                    start  = 1'b0;
                    check("vox_err_pulse", vox_err, 1);
                end
                if (cyc == 7) check("vox_err_clear", vox_err, 0);
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fb.fb_we) begin
                if (wr_cnt == 0 && seen < hold) begin
                    if (seen == 0) begin
                        ha = fb.fb_addr;
                        hd = fb.fb_d;
                    end else begin
                        check("hold_addr", fb.fb_addr, ha);
                        check("hold_data", fb.fb_d, hd);
                    end
                    seen++;
                    rdy = 1'b0;
                end
                if (rdy && wr_cnt < 64) begin
                    got_addr[wr_cnt] = int'(fb.fb_addr);
                    got_data[wr_cnt] = int'(fb.fb_d);
                    check("fb_addr", fb.fb_addr, exp_addr[wr_cnt]);
                    check("fb_data", fb.fb_d, exp_data[wr_cnt]);
                    wr_cnt++;
                end
            end
            fb.fb_ready = rdy;
            if (abort_after > 0 && wr_cnt == abort_after && rdy && fb.fb_we) begin
                @(posedge clk);
                #1 reset = 1'b1;
                #1;
                check("abort_busy", busy, 0);
                check("abort_fb_we", fb.fb_we, 0);
                fb.fb_ready = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        fb.fb_ready = 1'b0;
        check("render_timeout", cyc < 4000, 1);
        check("write_count", wr_cnt, 64);
        check("done_count", done_cnt, 1);
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
        if (!rnd && hold == 0) check("cycle_cost", busy_cyc, exp_cost);
    endtask

    initial begin
        int nz;
        reset = 1'b1; start = 1'b0; mode = '0;
        vox_we = 1'b0; vox_addr = '0; vox_d = 1'b0;
        fb.fb_ready = 1'b0;
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
                for (int z = 0; z < N; z++)
                    vox[x][y][z] = 1'((x + y + z) & 1);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vox_err", vox_err, 0);
        check("rst_fb_we", fb.fb_we, 0);
        check("rst_fb_addr", fb.fb_addr, 0);
        check("rst_fb_d", fb.fb_d, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Parity image, top view, always ready.
        render(2'd0, 1'b0, 0, 0, 1'b0);
        check("col00_addr", got_addr[0], 0);
        check("col00_data", got_data[0], 32'hDF);
        check("col10_addr", got_addr[1], 1);
        check("col10_data", got_data[1], 32'hFF);
        check("col01_addr", got_addr[8], 32);
        check("col01_data", got_data[8], 32'hFF);

        // First write back-pressured for 10 cycles.
        render(2'd2, 1'b0, 10, 0, 1'b0);
        render(2'd1, 1'b1, 0, 0, 1'b0);

        // Reset after the 10th write, then a full render from (0,0).
        render(2'd0, 1'b0, 0, 10, 1'b0);
        check("post_abort_busy", busy, 0);
        render(2'd0, 1'b0, 0, 0, 1'b0);
        check("restart_first_addr", got_addr[0], 0);

        // Single voxel at {2,3,5}.
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
                for (int z = 0; z < N; z++)
                    vox_write(x, y, z, 1'b0);
        vox_write(2, 3, 5, 1'b1);
        render(2'd0, 1'b0, 0, 0, 1'b0);
        check("single_top_addr", got_addr[26], 98);
        check("single_top_data", got_data[26], 32'h5F);
        nz = 0;
        for (int i = 0; i < 64; i++) if (got_data[i] != 0) nz++;
        check("single_top_nonzero", nz, 1);
        render(2'd1, 1'b0, 0, 0, 1'b0);
        check("single_front_addr", got_addr[42], 162);
        check("single_front_data", got_data[42], 32'h9F);

        // Random contents; writes/start during a render must be ignored.
        for (int i = 0; i < 80; i++)
            vox_write($urandom_range(0, N-1), $urandom_range(0, N-1),
                      $urandom_range(0, N-1), 1'($urandom_range(0, 1)));
        render(2'd0, 1'b1, 0, 0, 1'b1);
        render(2'd0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 64; i++) saved_data[i] = got_data[i];
        render(2'd3, 1'b1, 0, 0, 1'b0);
        nz = 0;
        for (int i = 0; i < 64; i++) if (got_data[i] != saved_data[i]) nz++;
        check("mode3_vs_mode0", nz, 0);
        render(2'd2, 1'b1, 0, 0, 1'b0);
        render(2'd1, 1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/voxel_projector.md
Name: voxel_projector

Overview:
Parametrised voxel renderer that owns an N×N×N 1-bit voxel store and projects it onto the 8-bit framebuffer RAM, one pixel per projected column. It is triggered once per frame (typically at vblank) and supports three view axes. For each column it emits the nearest occupied voxel, depth-shaded, or a background colour. Framebuffer writes go through a valid/ready handshake so the block can share the RAM port with other writers.

Parameters:
VX_BITS, 3, bits per axis coordinate; grid is N = 2^VX_BITS per side.
FB_ADDR_W, 12, framebuffer address width.
FB_BASE, 0, framebuffer address of projected pixel (u=0,v=0).
FB_STRIDE, 32, framebuffer address step per projected row v.
BG_COLOR, 8'h00, pixel value for a column with no occupied voxel.
INIT_PARITY, 1, if 1 the voxel store initialises to (x+y+z)[0]; if 0 it initialises to all zero.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle render request
mode  in  2  view select, sampled on accepted start
busy  out  1  render in progress
done  out  1  one-cycle pulse at render completion
vox_we  in  1  voxel store write enable
vox_addr  in  3*VX_BITS  voxel address {x,y,z}
vox_d  in  1  voxel write data
vox_err  out  1  one-cycle pulse: voxel write dropped because busy
fb_we  out  1  framebuffer write valid
fb_ready  in  1  framebuffer port accepts write
fb_addr  out  FB_ADDR_W  framebuffer write address
fb_d  out  8  framebuffer write data

Behaviour:
- Reset: busy=0, done=0, vox_err=0, fb_we=0, fb_addr=0, fb_d=0, FSM=IDLE, counters=0. Voxel store contents are not cleared by reset. Reset mid-render aborts immediately with no further fb writes.
- Voxel store: synchronous read, 1-cycle latency, addressed {x,y,z} with x as MSBs. Writes are accepted only when busy=0. vox_we while busy is dropped and vox_err pulses on the next cycle.
- start is accepted only in IDLE; start while busy is ignored. mode is latched on acceptance.
- Mode mapping (u,v,depth): 0 = (x,y,z) top; 1 = (x,z,y) front; 2 = (y,z,x) side; 3 = treated as 0.
- Column order: u increments fastest, then v. N*N columns per render.
- FSM: IDLE -> RD on accepted start, busy=1 the cycle after start. RD drives the store address for the current (u,v,d) -> TST. TST examines the returned bit:
  - Occupied: pixel = 8'hFF - (d << (8-VX_BITS)), truncated to 8 bits; go to WR.
  - Empty with d<N-1: d++, go to RD.
  - Empty with d=N-1: pixel = BG_COLOR; go to WR.
- WR: fb_we=1, fb_addr = FB_BASE + v*FB_STRIDE + u (modulo 2^FB_ADDR_W), fb_d = pixel. fb_we, fb_addr and fb_d are held stable until fb_we&&fb_ready.
  - On transfer with more columns remaining: d=0, advance (u,v), go to RD.
  - On transfer of the last column: go to DONE.
- DONE: one cycle with done=1. busy is 0 in the same cycle, then the FSM returns to IDLE.
- Cost with fb_ready=1: a hit at depth d costs 2(d+1)+1 cycles; an empty column costs 2N+1 cycles.

Decomposition:
- Shared package voxel_pkg: mode encoding constants (MODE_TOP, MODE_FRONT, MODE_SIDE) and FSM state enum.
- One sub-module: voxel_store, a 1-bit synchronous single-port RAM with INIT_PARITY initialisation and a write-inhibit input.
- The axis permutation and shading stay in the top level.

Test Plan:
- INIT_PARITY=1, mode 0, fb_ready=1:
  - Column (u,v)=(0,0) writes addr 0, data 8'hDF (hit at z=1).
  - Column (1,0) writes addr 1, data 8'hFF.
  - Column (0,1) writes addr 32, data 8'hFF.
  - Exactly 64 writes occur, then done pulses once.
- INIT_PARITY=0, single voxel set at {x=2,y=3,z=5}:
  - mode 0 writes addr 98, data 8'h5F; all other 63 writes are 8'h00.
  - mode 1 writes addr 162 (u=2,v=5), data 8'h9F (depth 3).
- fb_ready held 0 for 10 cycles on the first write -> fb_we/fb_addr/fb_d stable throughout; the write transfers on the first cycle ready=1, and no column is skipped or repeated.
- vox_we pulsed while busy -> store unchanged, vox_err pulses once; start pulsed while busy -> ignored, mode not re-latched.
- reset asserted mid-render after the 10th write -> busy/fb_we drop to 0 immediately. A following start renders all 64 columns again from (0,0), with voxel contents intact.
- mode 3 -> output identical to mode 0.
